// File: rtl/sipo_byte_rx.sv
// rtl/sipo_byte_rx.sv - serial-in parallel-out word assembler with valid/ready output
// Optional even-parity bit and parity_err port when PARITY_CHECK_EN is defined.
module sipo_byte_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic             parity_err
`endif
);

`ifdef PARITY_CHECK_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_done;
  logic             take;
  logic             slot_free;
`ifdef PARITY_CHECK_EN
  logic             par_acc;
  logic             hold_perr;
  logic             perr_done;
`endif

  assign take      = byte_valid && byte_ready;
  assign slot_free = !byte_valid || take;

  always_comb begin
    if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], sin};
    else           shifted = {sin, sreg[WIDTH-1:1]};
  end

  // With parity the final sampled bit is the parity bit, so the data word is already complete in sreg.
  always_comb begin
`ifdef PARITY_CHECK_EN
    word_done = sreg;
    perr_done = par_acc ^ sin;
`else
    word_done = shifted;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_acc    <= 1'b0;
      hold_perr  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // A transfer empties the slot unless a new word loads below on the same edge.
      if (take) byte_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef PARITY_CHECK_EN
            par_acc <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (sin_valid) begin
            if (cnt == LAST) begin
              if (slot_free) begin
                byte_out   <= word_done;
                byte_valid <= 1'b1;
                state      <= IDLE;
                busy       <= 1'b0;
`ifdef PARITY_CHECK_EN
                parity_err <= perr_done;
`endif
              end else begin
                sreg  <= word_done;
                state <= HOLD;
`ifdef PARITY_CHECK_EN
                hold_perr <= perr_done;
`endif
              end
            end else begin
              sreg <= shifted;
              cnt  <= cnt + CW'(1);
`ifdef PARITY_CHECK_EN
              par_acc <= par_acc ^ sin;
`endif
            end
          end
        end

        HOLD: begin
          if (sin_valid || start) overrun <= 1'b1;
          if (take) begin
            byte_out   <= sreg;
            byte_valid <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= hold_perr;
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_byte_rx.sv
// tb/tb_sipo_byte_rx.sv - directed self-checking bench for sipo_byte_rx
module tb_sipo_byte_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sin;
  logic       sin_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       overrun;
`ifdef PARITY_CHECK_EN
  logic       parity_err;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sipo_byte_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .overrun    (overrun)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    start     = 1'b0;
    sin_valid = 1'b0;
    tick();
  endtask

  task automatic bit_in(input logic b);
    start     = 1'b0;
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  // sin_valid is high in the start cycle to show it is ignored there.
  task automatic start_pulse();
    start     = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b1;
    tick();
    start     = 1'b0;
    sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap1, input int gap2);
    for (int i = 0; i < 8; i++) begin
      bit_in(w[7-i]);
      if (i + 1 == gap1 || i + 1 == gap2) idle_cyc();
    end
`ifdef PARITY_CHECK_EN
    bit_in(^w);
`endif
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; start = 1'b1; sin = 1'b1; sin_valid = 1'b1; byte_ready = 1'b0;
    tick();
    tick();
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    idle_cyc();
    check("idle_busy", busy, 1'b0);

    // Basic word 0xA5 with consumer ready
    byte_ready = 1'b1;
    start_pulse();
    check("basic_busy_after_start", busy, 1'b1);
    w = 8'hA5;
    for (int i = 0; i < 7; i++) bit_in(w[7-i]);
    check("basic_valid_before_last", byte_valid, 1'b0);
    bit_in(w[0]);
`ifdef PARITY_CHECK_EN
    bit_in(1'b0);
`endif
    check("basic_byte_out", byte_out, 8'hA5);
    check("basic_valid", byte_valid, 1'b1);
    check("basic_busy_done", busy, 1'b0);

    // Back-to-back start; the previous word is consumed on this edge
    start_pulse();
    check("b2b_valid_cleared", byte_valid, 1'b0);
    check("b2b_busy", busy, 1'b1);

    // Gaps after bits 3 and 6
    send_word(8'hA5, 3, 6);
    check("gap_byte_out", byte_out, 8'hA5);
    check("gap_valid", byte_valid, 1'b1);
    idle_cyc();
    check("gap_valid_one_cycle", byte_valid, 1'b0);

    // Back-pressure: 0x3C held, 0xC3 parked in HOLD
    byte_ready = 1'b0;
    start_pulse();
    send_word(8'h3C, 0, 0);
    check("bp_first_out", byte_out, 8'h3C);
    check("bp_first_valid", byte_valid, 1'b1);
    check("bp_first_busy", busy, 1'b0);
    start_pulse();
    send_word(8'hC3, 0, 0);
    check("bp_hold_busy", busy, 1'b1);
    check("bp_hold_out", byte_out, 8'h3C);
    check("bp_hold_valid", byte_valid, 1'b1);
    check("bp_no_overrun_yet", overrun, 1'b0);
    bit_in(1'b1);
    check("bp_overrun_set", overrun, 1'b1);
    check("bp_out_stable", byte_out, 8'h3C);
    byte_ready = 1'b1;
    idle_cyc();
    byte_ready = 1'b0;
    check("bp_release_out", byte_out, 8'hC3);
    check("bp_release_valid", byte_valid, 1'b1);
    check("bp_release_busy", busy, 1'b0);
    idle_cyc();
    check("bp_second_held", byte_out, 8'hC3);
    check("bp_overrun_sticky", overrun, 1'b1);
    byte_ready = 1'b1;
    idle_cyc();
    check("bp_second_consumed", byte_valid, 1'b0);
    check("bp_overrun_still", overrun, 1'b1);

    // Reset mid-word, then 0xFF
    start_pulse();
    for (int i = 0; i < 4; i++) bit_in(1'b1);
    rst = 1'b1;
    idle_cyc();
    rst = 1'b0;
    check("mid_rst_out", byte_out, 8'h00);
    check("mid_rst_valid", byte_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    start_pulse();
    send_word(8'hFF, 0, 0);
    check("post_rst_out", byte_out, 8'hFF);
    check("post_rst_valid", byte_valid, 1'b1);

`ifdef PARITY_CHECK_EN
    start_pulse();
    send_word(8'hA5, 0, 0);
    check("par_ok_out", byte_out, 8'hA5);
    check("par_ok_err", parity_err, 1'b0);
    start_pulse();
    w = 8'hA5;
    for (int i = 0; i < 8; i++) bit_in(w[7-i]);
    bit_in(1'b1);
    check("par_bad_out", byte_out, 8'hA5);
    check("par_bad_err", parity_err, 1'b1);
`endif

    idle_cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
